// File: rtl/timer_state_pkg.sv
// timer_state_pkg: shared types and constants for the timer state controller.
//   wr_sel_e     : software write target encoding (3'b111 reserved, ignored)
//   CMP_RESET    : reset value of every committed mtimecmp
//   SHADOW_RESET : reset value of every mtimecmp low-half shadow
//   MAX_HARTS    : largest supported hart count
//   hart_width() : width of a hart index, never below 1
package timer_state_pkg;

  typedef enum logic [2:0] {
    MTIME_LO    = 3'd0,
    MTIME_HI    = 3'd1,
    CMP_LO      = 3'd2,
    CMP_HI      = 3'd3,
    INTR_STATE  = 3'd4,
    INTR_ENABLE = 3'd5,
    INTR_TEST   = 3'd6
  } wr_sel_e;

  localparam logic [63:0] CMP_RESET    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] SHADOW_RESET = 32'hFFFF_FFFF;
  localparam int          MAX_HARTS    = 16;

  function automatic int hart_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_state_ctrl_if.sv
// timer_state_ctrl_if: 32-bit software write port from the register decoder.
//   wr_en   : single-cycle write strobe
//   wr_sel  : write target (wr_sel_e)
//   wr_hart : hart index for CMP_LO / CMP_HI
//   wr_data : write data
// Modports: master (register decoder side), slave (timer_state_ctrl side).
interface timer_state_ctrl_if #(
  parameter int N = 1
);
  import timer_state_pkg::*;

  localparam int HW = hart_width(N);

  logic          wr_en;
  wr_sel_e       wr_sel;
  logic [HW-1:0] wr_hart;
  logic [31:0]   wr_data;

  modport master (output wr_en, wr_sel, wr_hart, wr_data);
  modport slave  (input  wr_en, wr_sel, wr_hart, wr_data);

endinterface

// File: rtl/timer_state_hart.sv
// timer_state_hart: per-hart compare and interrupt state.
// Optional feature macro: TIMER_STATE_CMP_AUTOCLR_EN (a CMP_HI commit also
// clears this hart's pending bit, raw/test set still wins).
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_cmp_lo_we    : write low-half shadow from i_wr_data
//   i_cmp_hi_we    : commit {i_wr_data, shadow} to o_mtimecmp
//   i_wr_data      : software write data
//   i_clr, i_test  : write-1-to-clear / force-set of the pending bit
//   i_en_we        : load enable bit from i_en_data
//   i_raw          : raw compare level from the timer core
//   o_mtimecmp     : committed compare value
//   o_state        : sticky pending bit
//   o_enable       : enable bit
//   o_intr         : o_state & o_enable
module timer_state_hart
  import timer_state_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmp_lo_we,
  input  logic        i_cmp_hi_we,
  input  logic [31:0] i_wr_data,
  input  logic        i_clr,
  input  logic        i_test,
  input  logic        i_en_we,
  input  logic        i_en_data,
  input  logic        i_raw,
  output logic [63:0] o_mtimecmp,
  output logic        o_state,
  output logic        o_enable,
  output logic        o_intr
);

  logic [31:0] r_shadow;
  logic [63:0] r_mtimecmp;
  logic        r_state;
  logic        r_enable;
  logic        w_clr_eff;

`ifdef TIMER_STATE_CMP_AUTOCLR_EN
  assign w_clr_eff = i_clr | i_cmp_hi_we;
`else
  assign w_clr_eff = i_clr;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow   <= SHADOW_RESET;
      r_mtimecmp <= CMP_RESET;
      r_state    <= 1'b0;
      r_enable   <= 1'b0;
    end else begin
      // Low half is only staged; the core sees the full value at the HI commit.
      if (i_cmp_lo_we) r_shadow <= i_wr_data;
      if (i_cmp_hi_we) r_mtimecmp <= {i_wr_data, r_shadow};
      // Set terms are ORed after the clear so set wins in the same cycle.
      r_state <= (r_state & ~w_clr_eff) | i_raw | i_test;
      if (i_en_we) r_enable <= i_en_data;
    end
  end

  assign o_mtimecmp = r_mtimecmp;
  assign o_state    = r_state;
  assign o_enable   = r_enable;
  assign o_intr     = r_state & r_enable;

endmodule

// File: rtl/timer_state_ctrl.sv
// timer_state_ctrl: architectural mtime / mtimecmp registers and sticky,
// maskable timer interrupts, fed by the timer tick/compare core.
// Optional feature macro: TIMER_STATE_CMP_AUTOCLR_EN (see timer_state_hart).
// Parameter N: number of harts, 1..16. Hart index width is derived.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tick_i         : load mtime from mtime_d_i
//   mtime_d_i      : next mtime from the core
//   intr_raw_i     : raw compare levels, one per hart
//   wr_if          : software write port (slave modport)
//   mtime_o        : current mtime
//   mtimecmp_o     : committed compare values, one per hart
//   intr_state_o   : sticky pending bits
//   intr_enable_o  : enable bits
//   intr_o         : intr_state_o & intr_enable_o
module timer_state_ctrl
  import timer_state_pkg::*;
#(
  parameter int N = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tick_i,
  input  logic [63:0]   mtime_d_i,
  input  logic [N-1:0]  intr_raw_i,
  timer_state_ctrl_if.slave wr_if,
  output logic [63:0]   mtime_o,
  output logic [63:0]   mtimecmp_o [N],
  output logic [N-1:0]  intr_state_o,
  output logic [N-1:0]  intr_enable_o,
  output logic [N-1:0]  intr_o
);

  localparam int HW = hart_width(N);

  logic         w_sw_mtime_lo;
  logic         w_sw_mtime_hi;
  logic         w_sel_cmp_lo;
  logic         w_sel_cmp_hi;
  logic         w_en_we;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_test;
  logic [63:0]  r_mtime;
  logic [63:0]  w_mtime_next;

  // Reserved encodings match none of these, so such writes have no effect.
  assign w_sw_mtime_lo = wr_if.wr_en && (wr_if.wr_sel == MTIME_LO);
  assign w_sw_mtime_hi = wr_if.wr_en && (wr_if.wr_sel == MTIME_HI);
  assign w_sel_cmp_lo  = wr_if.wr_en && (wr_if.wr_sel == CMP_LO);
  assign w_sel_cmp_hi  = wr_if.wr_en && (wr_if.wr_sel == CMP_HI);
  assign w_en_we       = wr_if.wr_en && (wr_if.wr_sel == INTR_ENABLE);
  assign w_clr  = (wr_if.wr_en && (wr_if.wr_sel == INTR_STATE)) ? wr_if.wr_data[N-1:0] : '0;
  assign w_test = (wr_if.wr_en && (wr_if.wr_sel == INTR_TEST))  ? wr_if.wr_data[N-1:0] : '0;

  // Tick loads the whole word, then a software half-write overrides its half.
  always_comb begin
    w_mtime_next = r_mtime;
    if (tick_i)        w_mtime_next = mtime_d_i;
    if (w_sw_mtime_lo) w_mtime_next[31:0]  = wr_if.wr_data;
    if (w_sw_mtime_hi) w_mtime_next[63:32] = wr_if.wr_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_mtime <= '0;
    else       r_mtime <= w_mtime_next;
  end

  assign mtime_o = r_mtime;

  // Each hart only matches its own index, so out-of-range indices hit nothing.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_hart
      logic w_hart_hit;
      assign w_hart_hit = (wr_if.wr_hart == HW'(gi));

      timer_state_hart u_hart (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_cmp_lo_we (w_sel_cmp_lo & w_hart_hit),
        .i_cmp_hi_we (w_sel_cmp_hi & w_hart_hit),
        .i_wr_data   (wr_if.wr_data),
        .i_clr       (w_clr[gi]),
        .i_test      (w_test[gi]),
        .i_en_we     (w_en_we),
        .i_en_data   (wr_if.wr_data[gi]),
        .i_raw       (intr_raw_i[gi]),
        .o_mtimecmp  (mtimecmp_o[gi]),
        .o_state     (intr_state_o[gi]),
        .o_enable    (intr_enable_o[gi]),
        .o_intr      (intr_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_timer_state_ctrl.sv
// tb_timer_state_ctrl: scoreboard bench for timer_state_ctrl with N=3.
// The driver applies one transaction per cycle, updates a reference model
// and queues the expected register snapshot; the monitor pops and compares
// on the falling edge after the update edge.
module tb_timer_state_ctrl;
  import timer_state_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic [63:0]        mtime;
    logic [N-1:0][63:0] cmp;
    logic [N-1:0]       state;
    logic [N-1:0]       enable;
    logic [N-1:0]       intr;
  } snap_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         tick_i;
  logic [63:0]  mtime_d_i;
  logic [N-1:0] intr_raw_i;
  logic [63:0]  mtime_o;
  logic [63:0]  mtimecmp_o [N];
  logic [N-1:0] intr_state_o;
  logic [N-1:0] intr_enable_o;
  logic [N-1:0] intr_o;

  timer_state_ctrl_if #(.N(N)) wr_if ();

  timer_state_ctrl #(.N(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .tick_i        (tick_i),
    .mtime_d_i     (mtime_d_i),
    .intr_raw_i    (intr_raw_i),
    .wr_if         (wr_if),
    .mtime_o       (mtime_o),
    .mtimecmp_o    (mtimecmp_o),
    .intr_state_o  (intr_state_o),
    .intr_enable_o (intr_enable_o),
    .intr_o        (intr_o)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_txn   = 0;
  snap_t exp_q[$];

  // Reference model: architectural registers as plain variables.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp    [N];
  logic [31:0] m_shadow [N];
  logic [N-1:0] m_state, m_enable;

  task automatic model_reset();
    m_mtime = 64'd0;
    for (int h = 0; h < N; h++) begin
      m_cmp[h]    = 64'hFFFF_FFFF_FFFF_FFFF;
      m_shadow[h] = 32'hFFFF_FFFF;
    end
    m_state  = '0;
    m_enable = '0;
  endtask

  task automatic drive(input logic rst_v, input logic tick_v, input logic [63:0] d,
                       input logic [N-1:0] raw, input logic en, input logic [2:0] sel,
                       input logic [1:0] hart, input logic [31:0] data);
    logic [N-1:0] clr, tst;
    snap_t e;
    @(negedge clk);
    #1;
    rst_i         = rst_v;
    tick_i        = tick_v;
    mtime_d_i     = d;
    intr_raw_i    = raw;
    wr_if.wr_en   = en;
    wr_if.wr_sel  = wr_sel_e'(sel);
    wr_if.wr_hart = hart;
    wr_if.wr_data = data;
    if (rst_v) begin
      model_reset();
    end else begin
      if (tick_v) m_mtime = d;
      if (en && sel == 3'd0) m_mtime[31:0]  = data;
      if (en && sel == 3'd1) m_mtime[63:32] = data;
      clr = (en && sel == 3'd4) ? data[N-1:0] : '0;
      tst = (en && sel == 3'd6) ? data[N-1:0] : '0;
      for (int h = 0; h < N; h++) begin
        if (en && int'(hart) == h && sel == 3'd2) m_shadow[h] = data;
        if (en && int'(hart) == h && sel == 3'd3) begin
          m_cmp[h] = {data, m_shadow[h]};
`ifdef TIMER_STATE_CMP_AUTOCLR_EN
          clr[h] = 1'b1;
`endif
        end
      end
      m_state = (m_state & ~clr) | raw | tst;
      if (en && sel == 3'd5) m_enable = data[N-1:0];
    end
    e.mtime = m_mtime;
    for (int h = 0; h < N; h++) e.cmp[h] = m_cmp[h];
    e.state  = m_state;
    e.enable = m_enable;
    e.intr   = m_state & m_enable;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, '0, 1'b0, 3'd0, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [1:0] hart, input logic [31:0] data,
                    input logic [N-1:0] raw);
    drive(1'b0, 1'b0, 64'd0, raw, 1'b1, sel, hart, data);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s txn=%0d got=%h expected=%h", name, n_txn, act, exp);
    end
  endtask

  // Monitor: one snapshot per cycle after each driven edge.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        chk("mtime", mtime_o, e.mtime);
        for (int h = 0; h < N; h++) chk($sformatf("mtimecmp%0d", h), mtimecmp_o[h], e.cmp[h]);
        chk("intr_state", 64'(intr_state_o), 64'(e.state));
        chk("intr_enable", 64'(intr_enable_o), 64'(e.enable));
        chk("intr", 64'(intr_o), 64'(e.intr));
        $display("[TB] txn %0d mtime=%h cmp0=%h state=%b en=%b intr=%b",
                 n_txn, mtime_o, mtimecmp_o[0], intr_state_o, intr_enable_o, intr_o);
      end
    end
  end

  initial begin
    rst_i = 1'b1; tick_i = 1'b0; mtime_d_i = '0; intr_raw_i = '0;
    wr_if.wr_en = 1'b0; wr_if.wr_sel = MTIME_LO; wr_if.wr_hart = '0; wr_if.wr_data = '0;
    model_reset();

    // Reset then idle.
    drive(1'b1, 1'b0, 64'd0, '0, 1'b0, 3'd0, 2'd0, 32'd0);
    drive(1'b1, 1'b0, 64'd0, '0, 1'b0, 3'd0, 2'd0, 32'd0);
    idle(10);
    // Tick together with a software low-half write.
    drive(1'b0, 1'b1, 64'h0000_0001_0000_0005, '0, 1'b1, 3'd0, 2'd0, 32'hAAAA_0000);
    drive(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, '0, 1'b1, 3'd1, 2'd0, 32'h5555_0000);
    // Staged compare writes.
    wr(3'd2, 2'd0, 32'h100, '0);
    idle(5);
    wr(3'd3, 2'd0, 32'h0, '0);
    wr(3'd3, 2'd0, 32'h2, '0);
    // Test bit with enable low, then enable.
    wr(3'd6, 2'd0, 32'h1, '0);
    idle(1);
    wr(3'd5, 2'd0, 32'hFFFF_FFF9, '0);
    idle(1);
    wr(3'd4, 2'd0, 32'h1, '0);
    // Raw pulse, sticky, clear, set-wins.
    drive(1'b0, 1'b0, 64'd0, 3'b001, 1'b0, 3'd0, 2'd0, 32'd0);
    idle(2);
    wr(3'd4, 2'd0, 32'h1, '0);
    idle(1);
    wr(3'd4, 2'd0, 32'h1, 3'b001);
    wr(3'd4, 2'd0, 32'h7, 3'b001);
    wr(3'd4, 2'd0, 32'h7, '0);
    // Out-of-range hart and reserved select.
    wr(3'd2, 2'd3, 32'h7, '0);
    wr(3'd3, 2'd3, 32'h5, '0);
    wr(3'd7, 2'd0, 32'hFFFF_FFFF, '0);
    drive(1'b0, 1'b0, 64'd0, '0, 1'b0, 3'd3, 2'd1, 32'h77);
    // Compare commit with a pending bit, raw low then raw high.
    wr(3'd6, 2'd0, 32'h3, '0);
    wr(3'd3, 2'd0, 32'h9, '0);
    wr(3'd3, 2'd1, 32'hA, 3'b010);
    idle(1);
    // Mid-run reset drops the shadows too.
    wr(3'd2, 2'd1, 32'h1234, '0);
    drive(1'b1, 1'b0, 64'd0, '0, 1'b1, 3'd2, 2'd1, 32'h1);
    wr(3'd3, 2'd1, 32'h12, '0);

    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] raw;
      for (int b = 0; b < N; b++) raw[b] = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1),
            {$urandom, $urandom}, raw, $urandom_range(0, 1),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
    end
    idle(1);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
